// File: rtl/fdiv_fsqrt_rs.sv
// In-order-compacted reservation station for the FP divide/square-root unit.
// Operands wait on the CDB; the oldest ready entry is dispatched first.
module fdiv_fsqrt_rs #(
    parameter int unsigned N_ENTRY   = 4,
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic                         issue_op,
    input  logic [ROB_WIDTH-1:0]         issue_tag,
    input  logic [1:0]                   issue_opd_valid,
    input  logic [2*ROB_WIDTH-1:0]       issue_opd_tag,
    input  logic [63:0]                  issue_opd_data,
    input  logic                         cdb_valid,
    input  logic [ROB_WIDTH-1:0]         cdb_tag,
    input  logic [31:0]                  cdb_data,
    output logic                         disp_valid,
    input  logic                         disp_ready,
    output logic                         disp_op,
    output logic [ROB_WIDTH-1:0]         disp_tag,
    output logic [31:0]                  disp_a,
    output logic [31:0]                  disp_b,
    output logic [$clog2(N_ENTRY+1)-1:0] count
);
    localparam int unsigned CW = $clog2(N_ENTRY + 1);
    localparam int unsigned IW = $clog2(N_ENTRY);

    typedef struct packed {
        logic                   vld;
        logic                   op;
        logic [ROB_WIDTH-1:0]   tag;
        logic [1:0]             ov;
        logic [2*ROB_WIDTH-1:0] otag;
        logic [63:0]            od;
    } entry_t;

    entry_t [N_ENTRY-1:0] ent_q, ent_d;
    entry_t [N_ENTRY:0]   ext;
    entry_t               iss_ent;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        wr_idx;
    logic [N_ENTRY-1:0]   rdy;
    logic [IW-1:0]        sel;
    logic                 any_rdy;
    logic                 do_disp;
    logic                 do_issue;

    // Capture a broadcast into any still-empty operand of a valid entry.
    function automatic entry_t snoop(input entry_t e, input logic v,
                                     input logic [ROB_WIDTH-1:0] t, input logic [31:0] d);
        entry_t r;
        r = e;
        for (int k = 0; k < 2; k++) begin
            if (r.vld && !r.ov[k] && v && (r.otag[k*ROB_WIDTH +: ROB_WIDTH] == t)) begin
                r.ov[k]          = 1'b1;
                r.od[k*32 +: 32] = d;
            end
        end
        return r;
    endfunction

    always_comb begin
        any_rdy = 1'b0;
        sel     = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            rdy[i] = ent_q[i].vld & (&ent_q[i].ov);
        end
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                sel     = IW'(i);
                any_rdy = 1'b1;
            end
        end
    end

    assign disp_valid  = any_rdy & ~flush;
    assign disp_op     = disp_valid ? ent_q[sel].op : 1'b0;
    assign disp_tag    = disp_valid ? ent_q[sel].tag : '0;
    assign disp_a      = disp_valid ? ent_q[sel].od[31:0] : '0;
    assign disp_b      = disp_valid ? ent_q[sel].od[63:32] : '0;
    assign do_disp     = disp_valid & disp_ready;
    assign issue_ready = ~flush & ((count_q < CW'(N_ENTRY)) | do_disp);
    assign do_issue    = issue_valid & issue_ready;
    assign wr_idx      = count_q - CW'(do_disp);
    assign count       = count_q;

    always_comb begin
        iss_ent      = '0;
        iss_ent.vld  = 1'b1;
        iss_ent.op   = issue_op;
        iss_ent.tag  = issue_tag;
        iss_ent.ov   = issue_opd_valid;
        iss_ent.otag = issue_opd_tag;
        iss_ent.od   = issue_opd_data;
        // Square root has a single source; operand 1 is a constant zero.
        if (issue_op) begin
            iss_ent.ov[1]     = 1'b1;
            iss_ent.od[63:32] = '0;
        end
    end

    always_comb begin
        ext     = {entry_t'('0), ent_q};
        ent_d   = ent_q;
        count_d = count_q;
        for (int i = 0; i < N_ENTRY; i++) begin
            ent_d[i] = (do_disp && (IW'(i) >= sel)) ? ext[i+1] : ext[i];
            ent_d[i] = snoop(ent_d[i], cdb_valid, cdb_tag, cdb_data);
            if (do_issue && (CW'(i) == wr_idx)) begin
                ent_d[i] = snoop(iss_ent, cdb_valid, cdb_tag, cdb_data);
            end
        end
        unique case ({do_issue, do_disp})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            ent_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q   <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fdiv_fsqrt_rs.sv
// Scoreboard bench for fdiv_fsqrt_rs: expected dispatches are queued at issue
// and popped by an independent monitor whenever a dispatch handshake occurs.
module tb_fdiv_fsqrt_rs;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_op;
    logic [3:0]  issue_tag;
    logic [1:0]  issue_opd_valid;
    logic [7:0]  issue_opd_tag;
    logic [63:0] issue_opd_data;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        disp_valid;
    logic        disp_ready;
    logic        disp_op;
    logic [3:0]  disp_tag;
    logic [31:0] disp_a;
    logic [31:0] disp_b;
    logic [2:0]  count;

    typedef struct packed {
        logic        op;
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fdiv_fsqrt_rs #(.N_ENTRY(4), .ROB_WIDTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_op        (issue_op),
        .issue_tag       (issue_tag),
        .issue_opd_valid (issue_opd_valid),
        .issue_opd_tag   (issue_opd_tag),
        .issue_opd_data  (issue_opd_data),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .disp_valid      (disp_valid),
        .disp_ready      (disp_ready),
        .disp_op         (disp_op),
        .disp_tag        (disp_tag),
        .disp_a          (disp_a),
        .disp_b          (disp_b),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic op, input logic [3:0] tag,
                                input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.op  = op;
        e.tag = tag;
        e.a   = a;
        e.b   = b;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [3:0] tag, input logic [1:0] ov,
                         input logic [7:0] otag, input logic [63:0] od);
        issue_valid     = 1'b1;
        issue_op        = op;
        issue_tag       = tag;
        issue_opd_valid = ov;
        issue_opd_tag   = otag;
        issue_opd_data  = od;
        #1;
        chk("issue_ready_on_issue", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && disp_valid && disp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL disp_unexpected: got tag %0d, expected no dispatch", disp_tag);
            end else begin
                e = sb.pop_front();
                chk("disp_op", {31'd0, disp_op}, {31'd0, e.op});
                chk("disp_tag", {28'd0, disp_tag}, {28'd0, e.tag});
                chk("disp_a", disp_a, e.a);
                chk("disp_b", disp_b, e.b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        flush           = 1'b0;
        issue_valid     = 1'b0;
        issue_op        = 1'b0;
        issue_tag       = '0;
        issue_opd_valid = '0;
        issue_opd_tag   = '0;
        issue_opd_data  = '0;
        cdb_valid       = 1'b0;
        cdb_tag         = '0;
        cdb_data        = '0;
        disp_ready      = 1'b0;
        #12;
        chk("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single ready FDIV dispatched the cycle after issue.
        disp_ready = 1'b1;
        sb.push_back(mk(1'b0, 4'd3, 32'h4080_0000, 32'h4000_0000));
        issue(1'b0, 4'd3, 2'b11, 8'h00, {32'h4000_0000, 32'h4080_0000});
        chk("t1_count_1", {29'd0, count}, 32'd1);
        chk("t1_disp_valid", {31'd0, disp_valid}, 32'd1);
        tick();
        chk("t1_count_0", {29'd0, count}, 32'd0);

        // Older ready FDIV goes first; FSQRT waits on tag 2, no CDB bypass.
        disp_ready = 1'b0;
        sb.push_back(mk(1'b0, 4'd1, 32'h3F80_0000, 32'h4000_0000));
        issue(1'b0, 4'd1, 2'b11, 8'h00, {32'h4000_0000, 32'h3F80_0000});
        issue(1'b1, 4'd5, 2'b00, 8'h02, {32'hDEAD_BEEF, 32'h0000_0000});
        chk("t2_count_2", {29'd0, count}, 32'd2);
        disp_ready = 1'b1;
        tick();
        chk("t2_count_1", {29'd0, count}, 32'd1);
        chk("t2_sqrt_waiting", {31'd0, disp_valid}, 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd2;
        cdb_data  = 32'h4110_0000;
        sb.push_back(mk(1'b1, 4'd5, 32'h4110_0000, 32'h0));
        #1;
        chk("t2_no_bypass", {31'd0, disp_valid}, 32'd0);
        tick();
        cdb_valid = 1'b0;
        chk("t2_sqrt_ready", {31'd0, disp_valid}, 32'd1);
        tick();
        chk("t2_count_0", {29'd0, count}, 32'd0);

        // Fill, hold a rejected issue, then dispatch+issue in the same cycle.
        disp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(1'b0, 4'(8 + k), 32'h1000_0000 + k, 32'h2000_0000 + k));
            issue(1'b0, 4'(8 + k), 2'b11, 8'h00, {32'h2000_0000 + k, 32'h1000_0000 + k});
        end
        chk("t3_count_full", {29'd0, count}, 32'd4);
        chk("t3_issue_ready_full", {31'd0, issue_ready}, 32'd0);
        issue_valid     = 1'b1;
        issue_op        = 1'b0;
        issue_tag       = 4'd12;
        issue_opd_valid = 2'b11;
        issue_opd_data  = {32'h2000_000C, 32'h1000_000C};
        tick();
        chk("t3_rejected_issue", {29'd0, count}, 32'd4);
        disp_ready = 1'b1;
        sb.push_back(mk(1'b0, 4'd12, 32'h1000_000C, 32'h2000_000C));
        #1;
        chk("t3_issue_ready_swap", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("t3_count_swap", {29'd0, count}, 32'd4);
        repeat (5) tick();
        chk("t3_drained", {29'd0, count}, 32'd0);

        // CDB matches a new entry's missing operand on the issue cycle.
        cdb_valid = 1'b1;
        cdb_tag   = 4'd7;
        cdb_data  = 32'h3F80_0000;
        sb.push_back(mk(1'b0, 4'd6, 32'h4040_0000, 32'h3F80_0000));
        issue(1'b0, 4'd6, 2'b01, 8'h70, {32'h0, 32'h4040_0000});
        cdb_valid = 1'b0;
        chk("t4_ready", {31'd0, disp_valid}, 32'd1);
        tick();
        chk("t4_count_0", {29'd0, count}, 32'd0);

        // Ready entries 0 and 2 around a waiting entry 1.
        disp_ready = 1'b0;
        sb.push_back(mk(1'b0, 4'd1, 32'hA100_0000, 32'hB100_0000));
        sb.push_back(mk(1'b0, 4'd3, 32'hA300_0000, 32'hB300_0000));
        sb.push_back(mk(1'b0, 4'd2, 32'hA200_0000, 32'hD000_0009));
        issue(1'b0, 4'd1, 2'b11, 8'h00, {32'hB100_0000, 32'hA100_0000});
        issue(1'b0, 4'd2, 2'b01, 8'h90, {32'h0, 32'hA200_0000});
        issue(1'b0, 4'd3, 2'b11, 8'h99, {32'hB300_0000, 32'hA300_0000});
        chk("t5_count_3", {29'd0, count}, 32'd3);
        disp_ready = 1'b1;
        tick();
        chk("t5_count_2", {29'd0, count}, 32'd2);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd9;
        cdb_data  = 32'hD000_0009;
        tick();
        cdb_valid = 1'b0;
        chk("t5_count_1", {29'd0, count}, 32'd1);
        tick();
        chk("t5_count_0", {29'd0, count}, 32'd0);

        // Capture into an entry shifting down; set operands stay untouched.
        disp_ready = 1'b0;
        sb.push_back(mk(1'b0, 4'd1, 32'h1111_1111, 32'h2222_2222));
        sb.push_back(mk(1'b0, 4'd2, 32'hD000_000A, 32'h3333_3333));
        sb.push_back(mk(1'b0, 4'd4, 32'h4444_4444, 32'h5555_5555));
        issue(1'b0, 4'd1, 2'b11, 8'h00, {32'h2222_2222, 32'h1111_1111});
        issue(1'b0, 4'd2, 2'b10, 8'h0A, {32'h3333_3333, 32'h0});
        issue(1'b0, 4'd4, 2'b11, 8'hAA, {32'h5555_5555, 32'h4444_4444});
        disp_ready = 1'b1;
        cdb_valid  = 1'b1;
        cdb_tag    = 4'd10;
        cdb_data   = 32'hD000_000A;
        tick();
        cdb_valid = 1'b0;
        chk("t6_count_2", {29'd0, count}, 32'd2);
        repeat (2) tick();
        chk("t6_count_0", {29'd0, count}, 32'd0);

        // Flush overrides a pending issue and dispatch.
        disp_ready = 1'b0;
        issue(1'b0, 4'd1, 2'b11, 8'h00, {32'h1, 32'h2});
        issue(1'b0, 4'd2, 2'b11, 8'h00, {32'h3, 32'h4});
        issue(1'b0, 4'd3, 2'b11, 8'h00, {32'h5, 32'h6});
        chk("t7_count_3", {29'd0, count}, 32'd3);
        flush           = 1'b1;
        disp_ready      = 1'b1;
        issue_valid     = 1'b1;
        issue_tag       = 4'd13;
        issue_opd_valid = 2'b11;
        #1;
        chk("t7_flush_issue_ready", {31'd0, issue_ready}, 32'd0);
        chk("t7_flush_disp_valid", {31'd0, disp_valid}, 32'd0);
        tick();
        flush       = 1'b0;
        disp_ready  = 1'b0;
        issue_valid = 1'b0;
        chk("t7_flush_count", {29'd0, count}, 32'd0);
        chk("t7_flush_empty", {31'd0, disp_valid}, 32'd0);

        // Asynchronous reset between clock edges.
        issue(1'b1, 4'd7, 2'b01, 8'h00, {32'h0, 32'h4120_0000});
        issue(1'b0, 4'd8, 2'b11, 8'h00, {32'h1, 32'h2});
        chk("t8_count_2", {29'd0, count}, 32'd2);
        chk("t8_pre_disp_valid", {31'd0, disp_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t8_async_count", {29'd0, count}, 32'd0);
        chk("t8_async_disp_valid", {31'd0, disp_valid}, 32'd0);
        chk("t8_async_disp_op", {31'd0, disp_op}, 32'd0);
        chk("t8_async_disp_tag", {28'd0, disp_tag}, 32'd0);
        chk("t8_async_disp_a", disp_a, 32'd0);
        chk("t8_async_disp_b", disp_b, 32'd0);
        chk("t8_async_issue_ready", {31'd0, issue_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t8_post_count", {29'd0, count}, 32'd0);

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
